// File: rtl/mips_pkg.sv
// mips_pkg: shared state encoding, terminator word and loader defaults
package mips_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam logic [31:0] TERM_WORD = 32'hFFFF_FFFF;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_RUN_CYCLES = 64;
endpackage

// File: rtl/mips_prog_loader_if.sv
// mips_prog_loader_if: byte stream in, instruction-memory write port out
interface mips_prog_loader_if import mips_pkg::*; #(parameter int ADDR_W = DEF_ADDR_W);
  logic byte_valid;
  logic byte_ready;
  logic [7:0] byte_data;
  logic imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_wdata;
  modport master (input byte_valid, byte_data, output byte_ready, imem_we, imem_addr, imem_wdata);
  modport slave (output byte_valid, byte_data, input byte_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/mips_byte_packer.sv
// mips_byte_packer: assembles four big-endian bytes into a word, flags completion
module mips_byte_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [1:0] cnt;
  // shift bytes in MSB-first; word_valid marks the cycle after the fourth byte
  always_ff @(posedge clock) begin
    if (reset) begin
      word <= '0;
      cnt <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= in_valid && cnt == 2'd3;
      if (in_valid) begin
        word <= {word[23:0], in_data};
        cnt <= cnt + 2'd1;
      end
    end
  end
endmodule

// File: rtl/mips_prog_loader.sv
// mips_prog_loader: loads a byte-streamed program into imem, then runs the core for a fixed cycle budget
module mips_prog_loader import mips_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RUN_CYCLES = DEF_RUN_CYCLES
) (
  input  logic                      clock,
  input  logic                      reset,
  mips_prog_loader_if.master        bus,
  output logic                      core_reset,
  output logic                      running,
  output logic                      done,
  output logic [15:0]               cycle_count
);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [31:0] word;
  logic word_valid, xfer, term, we, full, leave;
  assign xfer = bus.byte_valid && bus.byte_ready;
  assign bus.imem_we = we;
  assign bus.imem_addr = addr;
  assign bus.imem_wdata = word;
  assign core_reset = state != RUN;
  assign running = state == RUN;
  assign done = state == DONE;
  mips_byte_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (xfer),
    .in_data    (bus.byte_data),
    .word       (word),
    .word_valid (word_valid)
  );
  // write strobe, load exit on terminator or full memory, and next state
  always_comb begin
    term = state == LOAD && word_valid && word == TERM_WORD;
    we = state == LOAD && word_valid && word != TERM_WORD;
    full = we && addr == {ADDR_W{1'b1}};
    leave = term || full;
    bus.byte_ready = state == IDLE || (state == LOAD && !leave);
    state_n = state == IDLE ? (xfer ? LOAD : IDLE) :
              state == LOAD ? (leave ? RUN : LOAD) :
              state == RUN  ? (cycle_count == 16'(RUN_CYCLES - 1) ? DONE : RUN) : DONE;
  end
  // state, write address and run-cycle counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      cycle_count <= '0;
    end else begin
      state <= state_n;
      if (we) addr <= addr + 1'b1;
      if (state == RUN) cycle_count <= cycle_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_mips_prog_loader.sv
// tb_mips_prog_loader: scoreboard bench for the program loader
module tb_mips_prog_loader;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  logic [39:0] q_a[$];
  logic [33:0] q_b[$];
  logic core_reset_a, running_a, done_a, core_reset_b, running_b, done_b;
  logic [15:0] cycle_count_a, cycle_count_b;

  mips_prog_loader_if #(.ADDR_W(8)) ifa ();
  mips_prog_loader_if #(.ADDR_W(2)) ifb ();

  mips_prog_loader #(.ADDR_W(8), .RUN_CYCLES(10)) dut_a (
    .clock(clock), .reset(reset), .bus(ifa.master),
    .core_reset(core_reset_a), .running(running_a), .done(done_a), .cycle_count(cycle_count_a)
  );
  mips_prog_loader #(.ADDR_W(2), .RUN_CYCLES(5)) dut_b (
    .clock(clock), .reset(reset), .bus(ifb.master),
    .core_reset(core_reset_b), .running(running_b), .done(done_b), .cycle_count(cycle_count_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (ifa.imem_we) begin
      check("a_we_expected", 64'(q_a.size() != 0), 1);
      if (q_a.size() != 0) check("a_write", {ifa.imem_addr, ifa.imem_wdata}, q_a.pop_front());
    end
    if (ifb.imem_we) begin
      check("b_we_expected", 64'(q_b.size() != 0), 1);
      if (q_b.size() != 0) check("b_write", {ifb.imem_addr, ifb.imem_wdata}, q_b.pop_front());
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic check_reset_a();
    check("rst_ready", ifa.byte_ready, 1);
    check("rst_we", ifa.imem_we, 0);
    check("rst_addr", ifa.imem_addr, 0);
    check("rst_wdata", ifa.imem_wdata, 0);
    check("rst_core_reset", core_reset_a, 1);
    check("rst_running", running_a, 0);
    check("rst_done", done_a, 0);
    check("rst_cycles", cycle_count_a, 0);
  endtask

  task automatic send(input bit sel, input logic [7:0] b);
    int n = 0;
    if (sel) begin ifb.byte_valid = 1'b1; ifb.byte_data = b; end
    else begin ifa.byte_valid = 1'b1; ifa.byte_data = b; end
    while (!(sel ? ifb.byte_ready : ifa.byte_ready) && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n == 50) check("ready_timeout", sel ? ifb.byte_ready : ifa.byte_ready, 1);
    @(negedge clock);
    if (sel) ifb.byte_valid = 1'b0;
    else ifa.byte_valid = 1'b0;
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) begin
      send(sel, w[8*i +: 8]);
      repeat (gap) @(negedge clock);
    end
  endtask

  task automatic finish_run_a();
    int n = 0;
    check("a_run_early", running_a, 0);
    @(negedge clock);
    check("a_running", running_a, 1);
    while (!core_reset_a && n < 100) begin
      n++;
      @(negedge clock);
    end
    check("a_run_len", n, 10);
    check("a_done", done_a, 1);
    check("a_final_cycles", cycle_count_a, 10);
    check("a_done_ready", ifa.byte_ready, 0);
    repeat (3) @(negedge clock);
    check("a_done_hold", done_a, 1);
    check("a_cycles_hold", cycle_count_a, 10);
    check("a_drain", q_a.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.byte_valid = 1'b0; ifa.byte_data = '0;
    ifb.byte_valid = 1'b0; ifb.byte_data = '0;
    @(negedge clock);
    do_reset();
    check_reset_a();
    // basic program with terminator
    q_a.push_back({8'd0, 32'h2008_0005});
    q_a.push_back({8'd1, 32'h2129_0001});
    send_word(0, 32'h2008_0005, 0);
    send_word(0, 32'h2129_0001, 0);
    send_word(0, 32'hFFFF_FFFF, 0);
    finish_run_a();
    // same program with idle gaps between bytes
    do_reset();
    q_a.push_back({8'd0, 32'h2008_0005});
    q_a.push_back({8'd1, 32'h2129_0001});
    send_word(0, 32'h2008_0005, 3);
    send_word(0, 32'h2129_0001, 3);
    send_word(0, 32'hFFFF_FFFF, 0);
    finish_run_a();
    // reset part way through word 1
    do_reset();
    q_a.push_back({8'd0, 32'h2008_0005});
    send_word(0, 32'h2008_0005, 0);
    send(0, 8'h21);
    send(0, 8'h29);
    check("a_addr_advanced", ifa.imem_addr, 1);
    do_reset();
    check_reset_a();
    q_a.push_back({8'd0, 32'h1122_3344});
    send_word(0, 32'h1122_3344, 0);
    send_word(0, 32'hFFFF_FFFF, 0);
    finish_run_a();
    // reset on the same edge as the fourth byte
    do_reset();
    send(0, 8'h20);
    send(0, 8'h08);
    send(0, 8'h00);
    ifa.byte_valid = 1'b1;
    ifa.byte_data = 8'h05;
    reset = 1'b1;
    @(negedge clock);
    ifa.byte_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("a_no_we_after_rst", ifa.imem_we, 0);
      @(negedge clock);
    end
    check("a_rst4_addr", ifa.imem_addr, 0);
    check("a_rst4_drain", q_a.size(), 0);
    // small memory fills without a terminator
    do_reset();
    for (int i = 0; i < 4; i++) q_b.push_back({2'(i), 32'hA000_0000 + 32'(i * 3 + 1)});
    for (int i = 0; i < 4; i++) send_word(1, 32'hA000_0000 + 32'(i * 3 + 1), 0);
    ifb.byte_valid = 1'b1;
    ifb.byte_data = 8'h55;
    check("b_ready_full", ifb.byte_ready, 0);
    @(negedge clock);
    check("b_running", running_b, 1);
    for (int i = 0; i < 3; i++) begin
      check("b_ready_run", ifb.byte_ready, 0);
      @(negedge clock);
    end
    ifb.byte_valid = 1'b0;
    repeat (4) @(negedge clock);
    check("b_done", done_b, 1);
    check("b_cycles", cycle_count_b, 5);
    check("b_drain", q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
